// File: rtl/reorder_buffer_p.sv
// AXI read-channel reorder buffer: re-tags ARs with slot indices, parks out-of-order R beats
// and returns them upstream in AR-acceptance order with the original ID restored.
module reorder_buffer_p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_WIDTH-1:0]      s_arid_i,
    input  logic                     s_arvalid_i,
    output logic                     s_arready_o,
    output logic [DATA_WIDTH-1:0]    s_rdata_o,
    output logic [1:0]               s_rresp_o,
    output logic [ID_WIDTH-1:0]      s_rid_o,
    output logic                     s_rvalid_o,
    input  logic                     s_rready_i,
    output logic [ID_WIDTH-1:0]      m_arid_o,
    output logic                     m_arvalid_o,
    input  logic                     m_arready_i,
    input  logic [DATA_WIDTH-1:0]    m_rdata_i,
    input  logic [1:0]               m_rresp_i,
    input  logic [ID_WIDTH-1:0]      m_rid_i,
    input  logic                     m_rvalid_i,
    output logic                     m_rready_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [ID_WIDTH:0] DEPTH_EXT = (ID_WIDTH + 1)'(DEPTH);

    logic [PW-1:0]         head_q, tail_q, count;
    logic [ID_WIDTH-1:0]   orig_id_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q    [DEPTH];
    logic [1:0]            resp_q    [DEPTH];
    logic [DEPTH-1:0]      busy_q, done_q;
    logic                  err_q;

    logic          full, alloc, pop, r_hs, r_tag_ok, r_accept;
    logic [AW-1:0] head_idx, tail_idx, r_idx;

    // Wrap bits make tail - head span 0..DEPTH without ambiguity.
    assign count    = tail_q - head_q;
    assign full     = (count == PW'(DEPTH));
    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];

    assign m_arvalid_o = s_arvalid_i & ~full;
    assign s_arready_o = m_arready_i & ~full;
    assign m_arid_o    = ID_WIDTH'(tail_idx);
    assign alloc       = s_arvalid_i & s_arready_o;

    assign m_rready_o = rst_n;
    assign r_hs       = m_rvalid_i & m_rready_o;
    assign r_tag_ok   = ({1'b0, m_rid_i} < DEPTH_EXT);
    assign r_idx      = m_rid_i[AW-1:0];
    assign r_accept   = r_hs & r_tag_ok & busy_q[r_idx] & ~done_q[r_idx];

    assign s_rvalid_o = busy_q[head_idx] & done_q[head_idx];
    assign s_rid_o    = orig_id_q[head_idx];
    assign s_rdata_o  = data_q[head_idx];
    assign s_rresp_o  = resp_q[head_idx];
    assign pop        = s_rvalid_o & s_rready_i;

    assign count_o = count;
    assign err_o   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                orig_id_q[i] <= '0;
                data_q[i]    <= '0;
                resp_q[i]    <= '0;
            end
        end else begin
            // Unallocated, already-answered or out-of-range tags are dropped.
            if (r_accept) begin
                data_q[r_idx] <= m_rdata_i;
                resp_q[r_idx] <= m_rresp_i;
                done_q[r_idx] <= 1'b1;
            end else if (r_hs) begin
                err_q <= 1'b1;
            end
            if (pop) begin
                busy_q[head_idx] <= 1'b0;
                done_q[head_idx] <= 1'b0;
                head_q           <= head_q + PW'(1);
            end
            if (alloc) begin
                orig_id_q[tail_idx] <= s_arid_i;
                busy_q[tail_idx]    <= 1'b1;
                done_q[tail_idx]    <= 1'b0;
                tail_q              <= tail_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Bench for reorder_buffer_p: directed scenarios plus random traffic checked against a
// queue-based model of outstanding reads.
module tb_reorder_buffer_p;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] s_arid_i = '0;
    logic          s_arvalid_i = 1'b0;
    logic          s_arready_o;
    logic [DW-1:0] s_rdata_o;
    logic [1:0]    s_rresp_o;
    logic [IW-1:0] s_rid_o;
    logic          s_rvalid_o;
    logic          s_rready_i = 1'b0;
    logic [IW-1:0] m_arid_o;
    logic          m_arvalid_o;
    logic          m_arready_i = 1'b0;
    logic [DW-1:0] m_rdata_i = '0;
    logic [1:0]    m_rresp_i = '0;
    logic [IW-1:0] m_rid_i = '0;
    logic          m_rvalid_i = 1'b0;
    logic          m_rready_o;
    logic [3:0]    count_o;
    logic          err_o;

    reorder_buffer_p #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Model: outstanding reads in acceptance order.
    typedef struct {
        logic [IW-1:0] id;
        int            tag;
        bit            done;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } ent_t;

    ent_t mq[$];
    bit   m_err;
    int   next_tag;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit full = (mq.size() == D);
        bit hv   = (mq.size() > 0) && mq[0].done;
        chk("s_arready", 32'(s_arready_o), 32'(m_arready_i & !full));
        chk("m_arvalid", 32'(m_arvalid_o), 32'(s_arvalid_i & !full));
        chk("m_arid", 32'(m_arid_o), 32'(next_tag % D));
        chk("m_rready", 32'(m_rready_o), 32'd1);
        chk("s_rvalid", 32'(s_rvalid_o), 32'(hv));
        if (hv) begin
            chk("s_rid", 32'(s_rid_o), 32'(mq[0].id));
            chk("s_rdata", 32'(s_rdata_o), 32'(mq[0].data));
            chk("s_rresp", 32'(s_rresp_o), 32'(mq[0].resp));
        end
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("err", 32'(err_o), 32'(m_err));
    endtask

    task automatic model_step();
        bit full  = (mq.size() == D);
        bit alloc = s_arvalid_i && m_arready_i && !full;
        bit pop   = (mq.size() > 0) && mq[0].done && s_rready_i;
        int found = -1;
        if (m_rvalid_i) begin
            foreach (mq[i]) if (mq[i].tag == int'(m_rid_i)) found = i;
            if (found >= 0 && !mq[found].done) begin
                mq[found].done = 1'b1;
                mq[found].data = m_rdata_i;
                mq[found].resp = m_rresp_i;
            end else begin
                m_err = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (alloc) begin
            mq.push_back('{id: s_arid_i, tag: next_tag % D, done: 1'b0, data: '0, resp: '0});
            next_tag++;
        end
    endtask

    // One clock: drive inputs, check outputs, clock, advance model.
    task automatic cyc(input bit arv, input logic [IW-1:0] arid, input bit mar, input bit rv,
                       input logic [IW-1:0] rid, input logic [DW-1:0] rd,
                       input logic [1:0] rr, input bit srr);
        s_arvalid_i = arv;
        s_arid_i    = arid;
        m_arready_i = mar;
        m_rvalid_i  = rv;
        m_rid_i     = rid;
        m_rdata_i   = rd;
        m_rresp_i   = rr;
        s_rready_i  = srr;
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_arvalid_i = 1'b0;
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b0;
        s_rready_i  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("rst_mrready", 32'(m_rready_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", 32'(s_rdata_o), 32'd0);
        chk("rst_rid", 32'(s_rid_o), 32'd0);
        chk("rst_rresp", 32'(s_rresp_o), 32'd0);
        rst_n = 1'b1;
        mq.delete();
        m_err    = 1'b0;
        next_tag = 0;
    endtask

    task automatic rand_resp(output bit rv, output logic [IW-1:0] rid);
        int cand[$];
        foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
        rv  = 1'b0;
        rid = '0;
        if (cand.size() > 0 && ($urandom % 2) == 1) begin
            rv  = 1'b1;
            rid = IW'(cand[$urandom_range(cand.size() - 1)]);
        end
    endtask

    initial begin
        bit            rv;
        logic [IW-1:0] rid;

        // In-order return of out-of-order responses, RRESP carried through.
        do_reset();
        cyc(1, 4'd3, 1, 0, 0, 0, 0, 0);
        cyc(1, 4'd7, 1, 0, 0, 0, 0, 0);
        cyc(1, 4'd1, 1, 0, 0, 0, 0, 0);
        chk("t1_count3", 32'(count_o), 32'd3);
        cyc(0, 0, 1, 1, 4'd2, 8'hA2, 2'b00, 0);
        chk("t1_no_early", 32'(s_rvalid_o), 32'd0);
        cyc(0, 0, 1, 1, 4'd0, 8'hA0, 2'b00, 0);
        chk("t1_v0", 32'(s_rvalid_o), 32'd1);
        chk("t1_id0", 32'(s_rid_o), 32'd3);
        chk("t1_d0", 32'(s_rdata_o), 32'hA0);
        cyc(0, 0, 1, 1, 4'd1, 8'hA1, 2'b10, 1);
        chk("t1_id1", 32'(s_rid_o), 32'd7);
        chk("t1_d1", 32'(s_rdata_o), 32'hA1);
        chk("t1_resp1", 32'(s_rresp_o), 32'd2);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        chk("t1_id2", 32'(s_rid_o), 32'd1);
        chk("t1_d2", 32'(s_rdata_o), 32'hA2);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        chk("t1_empty", 32'(s_rvalid_o), 32'd0);
        chk("t1_count0", 32'(count_o), 32'd0);

        // Fill to full, pop under full, tag wrap.
        do_reset();
        for (int i = 0; i < D; i++) cyc(1, IW'(15 - i), 1, 0, 0, 0, 0, 0);
        chk("full_count", 32'(count_o), 32'd8);
        cyc(1, 4'd9, 1, 0, 0, 0, 0, 0);
        chk("full_arready", 32'(s_arready_o), 32'd0);
        cyc(1, 4'd9, 1, 1, 4'd0, 8'h5A, 2'b00, 0);
        cyc(1, 4'd9, 1, 0, 0, 0, 0, 1);
        chk("pop_count", 32'(count_o), 32'd7);
        chk("pop_arready", 32'(s_arready_o), 32'd1);
        chk("wrap_tag", 32'(m_arid_o), 32'd0);
        cyc(1, 4'd9, 1, 0, 0, 0, 0, 0);
        chk("refill_count", 32'(count_o), 32'd8);

        // Backpressure on the upstream R channel.
        cyc(0, 0, 1, 1, 4'd1, 8'h55, 2'b01, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0);
            chk("bp_valid", 32'(s_rvalid_o), 32'd1);
            chk("bp_id", 32'(s_rid_o), 32'd14);
            chk("bp_data", 32'(s_rdata_o), 32'h55);
            chk("bp_count", 32'(count_o), 32'd8);
        end
        for (int k = 0; k < 200 && mq.size() > 0; k++) begin
            rand_resp(rv, rid);
            cyc(0, 0, 1, rv, rid, DW'($urandom), 2'($urandom), 1);
        end
        chk("drain_count", 32'(count_o), 32'd0);

        // Random legal traffic.
        for (int k = 0; k < 2000; k++) begin
            rand_resp(rv, rid);
            cyc($urandom % 2 == 1, IW'($urandom), ($urandom % 4) != 0, rv, rid,
                DW'($urandom), 2'($urandom), ($urandom % 3) != 0);
        end

        // Reset with outstanding slots; stale responses flag an error.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, IW'(i + 2), 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 4'd1, 8'h33, 2'b00, 0);
        chk("pre_rst_count", 32'(count_o), 32'd4);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_arready0", 32'(s_arready_o), 32'd0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("rst_arready1", 32'(s_arready_o), 32'd1);
        chk("rst_tag0", 32'(m_arid_o), 32'd0);
        cyc(1, 4'd6, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 4'd2, 8'h44, 2'b00, 0);
        chk("stale_err", 32'(err_o), 32'd1);

        // Idle-slot and duplicate responses.
        do_reset();
        cyc(1, 4'd10, 1, 0, 0, 0, 0, 0);
        cyc(1, 4'd11, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 4'd5, 8'hEE, 2'b00, 0);
        chk("idle_err", 32'(err_o), 32'd1);
        cyc(0, 0, 1, 1, 4'd0, 8'h11, 2'b00, 0);
        cyc(0, 0, 1, 1, 4'd0, 8'h99, 2'b11, 0);
        chk("dup_data", 32'(s_rdata_o), 32'h11);
        chk("dup_resp", 32'(s_rresp_o), 32'd0);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("err_sticky", 32'(err_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
